// File: rtl/imem_boot_loader.sv
// Fills instruction memory from a little-endian byte stream while holding the core in reset, then releases it.
// One write per 4 accepted bytes; every control output is decoded from state or comes straight from a register.
module imem_boot_loader #(
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load_start,
  input  logic [ADDR_WIDTH:0]   load_len,
  input  logic                  byte_valid,
  input  logic [7:0]            byte_data,
  output logic                  byte_ready,
  output logic                  imem_we,
  output logic [ADDR_WIDTH-1:0] imem_waddr,
  output logic [DATA_WIDTH-1:0] imem_wdata,
  output logic                  cpu_rst,
  output logic                  cpu_run,
  output logic                  busy,
  output logic                  done,
  output logic [ADDR_WIDTH:0]   word_count
);

  localparam logic [ADDR_WIDTH:0] MAX_LEN = {1'b1, {ADDR_WIDTH{1'b0}}};

  typedef enum logic [1:0] {IDLE, LOAD, WRITE, RUN} state_t;

  state_t                state;
  logic [1:0]            lane;
  logic [ADDR_WIDTH:0]   len;
  logic [DATA_WIDTH-1:0] word_buf;
  logic [ADDR_WIDTH:0]   next_count;

  assign next_count = word_count + 1'b1;

  assign byte_ready = (state == LOAD);
  assign imem_we    = (state == WRITE);
  assign cpu_run    = (state == RUN);
  assign cpu_rst    = (state != RUN);
  assign busy       = (state == LOAD) || (state == WRITE);
  assign imem_waddr = word_count[ADDR_WIDTH-1:0];
  assign imem_wdata = word_buf;

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      lane       <= 2'd0;
      len        <= '0;
      word_buf   <= '0;
      word_count <= '0;
      done       <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE, RUN: begin
          if (load_start) begin
            word_count <= '0;
            lane       <= 2'd0;
            if (load_len == '0) begin
              state <= RUN;
              done  <= 1'b1;
            end else begin
              state <= LOAD;
              // Clamp so the write address can never wrap onto word 0.
              len   <= (load_len > MAX_LEN) ? MAX_LEN : load_len;
            end
          end
        end
        LOAD: begin
          if (byte_valid) begin
            word_buf[{lane, 3'b000} +: 8] <= byte_data;
            lane <= lane + 2'd1;
            if (lane == 2'd3) state <= WRITE;
          end
        end
        WRITE: begin
          word_count <= next_count;
          lane       <= 2'd0;
          if (next_count == len) begin
            state <= RUN;
            done  <= 1'b1;
          end else begin
            state <= LOAD;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/imem_boot_loader.md
# imem_boot_loader

Sequencing controller that fills the single-cycle core's instruction memory from an 8-bit byte stream, then releases the core to execute. It holds the core in reset while loading, assembles little-endian 32-bit words and issues one write per word to the instruction memory's write port. After the last word it switches to RUN. It sits between the board-level byte source (UART receiver or test bench) and the instruction memory/CPU reset.

## Interface
- ADDR_WIDTH, 5, word-address width of instruction memory (depth 2^ADDR_WIDTH = 32 words)
- DATA_WIDTH, 32, instruction word width; fixed at 4 bytes
- clk  in  1  rising-edge clock
- rst  in  1  reset; one clock; reset is synchronous and active-high
- load_start  in  1  single-cycle request to begin a load
- load_len  in  ADDR_WIDTH+1  number of words to load, sampled when load_start is accepted
- byte_valid  in  1  byte_data is valid
- byte_data  in  8  stream byte
- byte_ready  out  1  loader accepts a byte this cycle
- imem_we  out  1  instruction-memory write enable
- imem_waddr  out  ADDR_WIDTH  word address of write
- imem_wdata  out  DATA_WIDTH  assembled instruction word
- cpu_rst  out  1  core reset; high whenever not in RUN
- cpu_run  out  1  high in RUN
- busy  out  1  high in LOAD or WRITE
- done  out  1  one-cycle pulse on entry to RUN
- word_count  out  ADDR_WIDTH+1  words written in current load

## Operation
- States: IDLE, LOAD, WRITE, RUN. All outputs are registered or decoded from state only.
- IDLE: load_start with load_len=0 -> RUN (done pulses). With load_len>0 -> LOAD. Latch len = min(load_len, 2^ADDR_WIDTH). Clear word_count and lane.
- LOAD: byte_ready=1. A byte transfers on byte_valid&&byte_ready. Byte at lane k goes to bits [8k+7:8k] (lane 0 = bits 7:0). The lane counter increments 0..3. Accepting the lane-3 byte -> WRITE.
- WRITE: one cycle. imem_we=1, imem_waddr=word_count[ADDR_WIDTH-1:0], imem_wdata=assembled word, byte_ready=0. On exit word_count+1 and lane resets to 0. If word_count+1 == len -> RUN, else -> LOAD.
- RUN: cpu_rst=0, cpu_run=1, byte_ready=0. load_start -> LOAD (reload) with cpu_rst reasserted the next cycle. The load_len=0 rule applies as in IDLE.
- load_start in LOAD or WRITE is ignored. byte_valid outside LOAD is ignored; no byte is consumed.
- load_len > 2^ADDR_WIDTH is clamped, so addresses never wrap.
- rst at any time -> IDLE. Partial words are discarded. Words already written remain in memory, since memory is not cleared.

## Timing
- Reset values:
  - state IDLE
  - byte_ready 0, imem_we 0, imem_waddr 0, imem_wdata 0
  - cpu_rst 1, cpu_run 0, busy 0, done 0, word_count 0
- load_start accepted at edge E -> byte_ready=1 from cycle E+1.
- 4th byte of a word accepted at edge N -> imem_we=1 during cycle N+1, with address and data stable that cycle. The memory captures at edge N+2.
- The next word's lane-0 byte can be accepted in cycle N+2. Minimum 5 cycles per word with continuous valid.
- Final WRITE cycle W -> cycle W+1: done=1, cpu_run=1, cpu_rst=0, word_count=len. done is low from W+2.
- word_count updates at the edge ending WRITE.
- busy is high exactly during LOAD and WRITE cycles.
- Gaps in byte_valid stall LOAD indefinitely; there is no timeout.

## Test plan
- Reset: assert rst 2 cycles mid-operation -> all outputs equal the reset values next cycle, cpu_rst=1.
- Single word: load_len=1, bytes 0x9F,0x00,0x10,0x00 -> one imem_we cycle, waddr=0, wdata=0x0010009F. done pulses 1 cycle later with cpu_run=1 and word_count=1.
- Multi-word with stalls: load_len=3, byte_valid toggled randomly, words 0x00000001/0x00000002/0x00000003 -> writes to addr 0,1,2 in order. Exactly 3 imem_we pulses, never two consecutive. byte_ready=0 in every WRITE cycle.
- Boundaries:
  - load_len=40 with 32 words sent -> last write at addr 31, then RUN, with no write to addr 0 after wrap.
  - load_len=0 -> RUN next cycle, done=1, no writes.
- Reload and ignore: in RUN, pulse load_start with load_len=1 -> cpu_rst=1 the next cycle, new word at addr 0. load_start pulsed during LOAD is ignored; byte_valid during RUN is not consumed.
- Reset mid-load: rst after 2 bytes of word 1 (word 0 already written) -> IDLE with no write for word 1. A new load_start with load_len=1 and bytes 0xAA,0xBB,0xCC,0xDD writes 0xDDCCBBAA at addr 0.
